// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN inference sequencer.
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    START,
    WAIT_DONE,
    TX,
    TX_WAIT
  } seq_state_t;

  localparam int         IMG_PIXELS = 784;
  localparam logic [7:0] ERR_BYTE   = 8'hFF;

  localparam int ADDR_W     = 10;
  localparam int BYTE_CNT_W = 7;
  localparam int BIT_CNT_W  = 3;
  localparam int WD_CNT_W   = 15;

endpackage

// File: rtl/pixel_unpacker.sv
// Byte-to-pixel serializer: loads a packed byte and shifts it out LSB first,
// flagging the eighth bit so the sequencer knows when the byte is exhausted.
module pixel_unpacker
  import snn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [7:0]           i_data,
  input  logic                 i_shift,
  output logic                 o_bit,
  output logic [BIT_CNT_W-1:0] o_bit_cnt,
  output logic                 o_last_bit
);

  logic [7:0]           r_shreg;
  logic [BIT_CNT_W-1:0] r_bit_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (i_load) begin
      r_shreg   <= i_data;
      r_bit_cnt <= '0;
    end else if (i_shift) begin
      r_shreg   <= {1'b0, r_shreg[7:1]};
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  assign o_bit      = r_shreg[0];
  assign o_bit_cnt  = r_bit_cnt;
  assign o_last_bit = (r_bit_cnt == '1);

endmodule

// File: rtl/snn_sequencer.sv
// Inference sequencer: UART bytes -> 1-bit input RAM -> snn_core -> UART digit.
// Define SNN_SEQ_WATCHDOG_EN to add a core_done watchdog that reports ERR_BYTE.
module snn_sequencer
  import snn_pkg::*;
#(
  parameter int NUM_BYTES = IMG_PIXELS / 8
`ifdef SNN_SEQ_WATCHDOG_EN
  ,
  parameter int TIMEOUT_CYC = 32768
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              clr_rx_rdy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic [3:0]        digit_out,
  output logic              busy
);

  seq_state_t            r_state;
  seq_state_t            w_state_nxt;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic                  r_clr_rx_rdy;
  logic [7:0]            r_tx_data;
  logic [3:0]            r_digit_out;

  logic                  w_load;
  logic                  w_shift;
  logic                  w_bit;
  logic [BIT_CNT_W-1:0]  w_bit_cnt;
  logic                  w_last_bit;
  logic                  w_frame_end;
  logic                  w_timeout;

  pixel_unpacker u_unpacker (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_data    (rx_data),
    .i_shift   (w_shift),
    .o_bit     (w_bit),
    .o_bit_cnt (w_bit_cnt),
    .o_last_bit(w_last_bit)
  );

  assign w_frame_end = (r_byte_cnt == BYTE_CNT_W'(NUM_BYTES - 1));

`ifdef SNN_SEQ_WATCHDOG_EN
  logic [WD_CNT_W-1:0] r_wd_cnt;
  logic [WD_CNT_W-1:0] w_wd_cnt_inc;

  // Fires on the WAIT_DONE cycle whose increment lands on TIMEOUT_CYC-1, so
  // tx_start follows core_start by exactly TIMEOUT_CYC cycles.
  assign w_wd_cnt_inc = r_wd_cnt + 1'b1;
  assign w_timeout    = (w_wd_cnt_inc == WD_CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (r_state == START) begin
      r_wd_cnt <= '0;
    end else if (r_state == WAIT_DONE) begin
      r_wd_cnt <= w_wd_cnt_inc;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_rdy) begin
          w_load      = 1'b1;
          w_state_nxt = UNPACK;
        end
      end
      UNPACK: begin
        w_shift = 1'b1;
        if (w_last_bit) begin
          w_state_nxt = w_frame_end ? START : IDLE;
        end
      end
      START:     w_state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (core_done || w_timeout) begin
          w_state_nxt = TX;
        end
      end
      TX:        w_state_nxt = TX_WAIT;
      TX_WAIT: begin
        if (tx_done) begin
          w_state_nxt = IDLE;
        end
      end
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt   <= '0;
      r_clr_rx_rdy <= 1'b0;
      r_tx_data    <= 8'h00;
      r_digit_out  <= 4'h0;
    end else begin
      r_clr_rx_rdy <= w_load;
      if (r_state == START) begin
        r_byte_cnt <= '0;
      end else if (w_shift && w_last_bit && !w_frame_end) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
      // core_done takes priority over a coincident watchdog expiry.
      if (r_state == WAIT_DONE) begin
        if (core_done) begin
          r_digit_out <= core_digit;
          r_tx_data   <= {4'h0, core_digit};
        end else if (w_timeout) begin
          r_tx_data   <= ERR_BYTE;
        end
      end
    end
  end

  assign clr_rx_rdy = r_clr_rx_rdy;
  assign ram_we     = (r_state == UNPACK);
  assign ram_addr   = ram_we ? {r_byte_cnt, w_bit_cnt} : '0;
  assign ram_data   = ram_we & w_bit;
  assign core_start = (r_state == START);
  assign tx_start   = (r_state == TX);
  assign tx_data    = r_tx_data;
  assign digit_out  = r_digit_out;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_snn_sequencer.sv
// Directed self-checking bench for snn_sequencer: frame load, result return,
// rx back-pressure, mid-frame reset and (with SNN_SEQ_WATCHDOG_EN) the watchdog.
module tb_snn_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       core_done = 1'b0;
  logic [3:0] core_digit = 4'h0;
  logic       tx_done = 1'b0;

  logic       clr_rx_rdy;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic       ram_data;
  logic       core_start;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] digit_out;
  logic       busy;

  snn_sequencer #(
    .NUM_BYTES(98)
`ifdef SNN_SEQ_WATCHDOG_EN
    ,
    .TIMEOUT_CYC(16)
`endif
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .clr_rx_rdy(clr_rx_rdy),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .core_start(core_start),
    .core_done (core_done),
    .core_digit(core_digit),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .digit_out (digit_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive RAM/handshake observer, sampled on the falling edge.
  logic       mem [0:783];
  logic [9:0] addr_log [0:8191];
  int n_wr = 0, n_start = 0, n_tx = 0, n_clr = 0;
  int wr783_cyc = -1, start_cyc = -1, max_addr = 0;

  always @(negedge clk) begin
    if (ram_we) begin
      if (ram_addr < 10'd784) mem[ram_addr] = ram_data;
      addr_log[n_wr % 8192] = ram_addr;
      n_wr++;
      if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
      if (ram_addr == 10'd783) wr783_cyc = cyc;
    end
    if (core_start) begin
      n_start++;
      start_cyc = cyc;
    end
    if (tx_start) n_tx++;
    if (clr_rx_rdy) n_clr++;
  end

  function automatic logic [7:0] pat(input int kind, input int i);
    case (kind)
      0:       return 8'hA5;
      1:       return 8'(i * 37 + 3);
      default: return 8'(~i);
    endcase
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok      = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (clr_rx_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    rx_rdy = 1'b0;
  endtask

  task automatic send_frame(input string tag, input int kind, input int n);
    int good;
    bit ok;
    good = 0;
    for (int i = 0; i < n; i++) begin
      send_byte(pat(kind, i), ok);
      if (ok) good++;
    end
    check({tag, "_consumed"}, good, n);
  endtask

  task automatic wait_start(input string tag, output int t);
    bit found;
    found = 1'b0;
    t     = -1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (core_start) begin
        found = 1'b1;
        t     = cyc;
        break;
      end
    end
    check({tag, "_start_seen"}, found, 1);
  endtask

  task automatic check_img(input string tag, input int kind);
    int errs;
    logic [7:0] b;
    errs = 0;
    for (int p = 0; p < 784; p++) begin
      b = pat(kind, p / 8);
      if (mem[p] !== b[p % 8]) errs++;
    end
    check(tag, errs, 0);
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  int t_start, base_wr, base_start, base_clr, base_tx, t_tx;
  bit found_tx;

  initial begin
    // Reset values
    tick(2);
    check("rst_clr_rx_rdy", clr_rx_rdy, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_core_start", core_start, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_digit_out", digit_out, 4'h0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // core_done while idle is ignored
    core_digit = 4'd3;
    core_done  = 1'b1;
    tick();
    core_done  = 1'b0;
    tick();
    check("idle_done_digit", digit_out, 4'h0);
    check("idle_done_busy", busy, 0);

    // Full frame of 8'hA5
    send_frame("a5", 0, 98);
    wait_start("a5", t_start);
    tick();
    check("a5_core_start_pulse", core_start, 0);
    check("a5_writes", n_wr, 784);
    check("a5_starts", n_start, 1);
    check("a5_addr0", mem[0], 1);
    check("a5_addr1", mem[1], 0);
    check("a5_addr783", mem[783], 1);
    check("a5_max_addr", max_addr, 783);
    check("a5_start_after_783", start_cyc - wr783_cyc, 1);
    check_img("a5_image", 0);
    check("wait_busy", busy, 1);

    // Byte pending during WAIT_DONE is held off until IDLE
    base_clr = n_clr;
    rx_data  = 8'h03;
    rx_rdy   = 1'b1;
    tick(4);
    check("wait_no_clr", n_clr - base_clr, 0);
    core_digit = 4'd7;
    core_done  = 1'b1;
    tick();
    core_done  = 1'b0;
    check("d7_tx_start", tx_start, 1);
    check("d7_tx_data", tx_data, 8'h07);
    check("d7_digit_out", digit_out, 4'd7);
    tick();
    check("d7_tx_start_single", tx_start, 0);
    tick(2);
    check("d7_tx_data_held", tx_data, 8'h07);
    tx_done = 1'b1;
    tick(0);
    check("txw_busy", busy, 1);
    tick();
    tx_done = 1'b0;
    check("txdone_busy_fall", busy, 0);
    check("txdone_no_clr_yet", clr_rx_rdy, 0);
    check("txw_no_clr", n_clr - base_clr, 0);
    tick();
    rx_rdy = 1'b0;
    check("pend_clr", clr_rx_rdy, 1);
    check("pend_we", ram_we, 1);
    check("pend_addr", ram_addr, 0);
    check("pend_data", ram_data, 1);

    // Partial frame (50 bytes in total), then reset mid-unpack
    send_frame("part", 1, 49);
    tick(3);
    rst_n = 1'b0;
    tick(2);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_we", ram_we, 0);
    check("mid_rst_digit", digit_out, 4'h0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    rst_n = 1'b1;
    tick();
    base_wr    = n_wr;
    base_start = n_start;
    send_frame("post", 1, 98);
    wait_start("post", t_start);
    tick();
    check("post_first_addr", addr_log[base_wr % 8192], 0);
    check("post_writes", n_wr - base_wr, 784);
    check("post_starts", n_start - base_start, 1);
    check("post_start_after_783", start_cyc - wr783_cyc, 1);
    check("post_digit_before", digit_out, 4'h0);
    check_img("post_image", 1);
`ifndef SNN_SEQ_WATCHDOG_EN
    base_tx = n_tx;
    tick(100);
    check("no_wd_no_tx", n_tx - base_tx, 0);
    check("no_wd_busy", busy, 1);
`endif
    core_digit = 4'd9;
    core_done  = 1'b1;
    tick();
    core_done  = 1'b0;
    check("d9_tx_start", tx_start, 1);
    check("d9_tx_data", tx_data, 8'h09);
    check("d9_digit_out", digit_out, 4'd9);
    tick();
    pulse_tx_done();
    check("d9_idle", busy, 0);

`ifdef SNN_SEQ_WATCHDOG_EN
    // Watchdog expiry: no core_done at all
    send_frame("wd", 2, 98);
    wait_start("wd", t_start);
    found_tx = 1'b0;
    t_tx     = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_start) begin
        found_tx = 1'b1;
        t_tx     = cyc;
        break;
      end
    end
    check("wd_tx_seen", found_tx, 1);
    check("wd_latency", t_tx - t_start, 16);
    check("wd_tx_data", tx_data, 8'hFF);
    check("wd_digit_kept", digit_out, 4'd9);
    tick();
    pulse_tx_done();

    // core_done in the expiry cycle wins
    send_frame("wd2", 0, 98);
    wait_start("wd2", t_start);
    tick(15);
    core_digit = 4'd4;
    core_done  = 1'b1;
    tick();
    core_done  = 1'b0;
    check("wd2_cycle", cyc - t_start, 16);
    check("wd2_tx_start", tx_start, 1);
    check("wd2_tx_data", tx_data, 8'h04);
    check("wd2_digit_out", digit_out, 4'd4);
    tick();
    pulse_tx_done();
`endif

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snn_sequencer.md
# snn_sequencer

Top-level controller that sequences one inference on the `snn_core` datapath. It receives a packed 28x28 binary image as bytes from the UART receiver and unpacks each byte into the 1-bit-wide input-unit RAM. It then pulses the core's `start`, waits for `done`, and returns the classified digit through the UART transmitter. It sits between the UART rx/tx wrappers and `snn_core` plus its input RAM.

## Interface
- NUM_BYTES, 98, packed image bytes per frame (8 pixels per byte, 784 pixels)
- TIMEOUT_CYC, 32768, watchdog limit in cycles for `core_done` (used only with the macro)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_rdy  in  1  level; a received byte is pending on rx_data
- rx_data  in  8  received byte
- clr_rx_rdy  out  1  one-cycle pulse; consumes the pending byte
- ram_we  out  1  input RAM write enable
- ram_addr  out  10  input RAM address (pixel index 0..783)
- ram_data  out  1  pixel bit
- core_start  out  1  one-cycle start pulse to `snn_core`
- core_done  in  1  one-cycle pulse from `snn_core`; core_digit is valid in that cycle
- core_digit  in  4  classified digit
- tx_start  out  1  one-cycle pulse; launches transmission of tx_data
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_done
- tx_done  in  1  one-cycle pulse; transmitter finished
- digit_out  out  4  last valid result, registered
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, UNPACK, START, WAIT_DONE, TX, TX_WAIT.
- IDLE:
  - If rx_rdy is high, capture rx_data into the shift register, pulse clr_rx_rdy and go to UNPACK.
  - If rx_rdy is low, stay in IDLE.
- UNPACK: 8 cycles, one ram_we per cycle.
  - ram_data is shift-register bit 0 (LSB first).
  - ram_addr = byte_cnt*8 + bit_cnt.
  - After bit 7: if byte_cnt == NUM_BYTES-1, go to START; else increment byte_cnt and go to IDLE.
- START: pulse core_start for 1 cycle, clear byte_cnt, go to WAIT_DONE.
- WAIT_DONE: on core_done, set digit_out <= core_digit and tx_data <= {4'h0, core_digit}, then go to TX.
- TX: pulse tx_start for 1 cycle, go to TX_WAIT.
- TX_WAIT: on tx_done, go to IDLE.
- Bytes arriving outside IDLE are not consumed. rx_rdy stays pending and is taken on the return to IDLE.
- core_done outside WAIT_DONE is ignored.
- Width rules: ram_addr is 10 bits, byte_cnt 7 bits, bit_cnt 3 bits. The address never exceeds 783.
- Reset mid-operation:
  - State returns to IDLE and byte_cnt/bit_cnt clear, so a partial image is discarded.
  - Input RAM contents are left as-is.

## Timing
- Reset values: clr_rx_rdy, ram_we, ram_addr, ram_data, core_start, tx_start = 0; tx_data = 8'h00; digit_out = 4'h0; busy = 0.
- All outputs are registered or decoded from the state/counter flops. No combinational path from inputs to outputs.
- Byte capture to first RAM write: 1 cycle. Each byte occupies 1 (IDLE) + 8 (UNPACK) cycles at minimum.
- Last pixel write (address 783) is followed by core_start in the next cycle.
- core_done to tx_start: 1 cycle (through TX).
- tx_done to IDLE: 1 cycle. busy falls in the same cycle the FSM reaches IDLE.

## Configuration
- SNN_SEQ_WATCHDOG_EN defined:
  - A 15-bit counter clears in START and increments in WAIT_DONE.
  - If the count reaches TIMEOUT_CYC-1 without core_done: tx_data <= 8'hFF, digit_out unchanged, go to TX.
  - If core_done and the timeout occur in the same cycle, core_done wins.
- SNN_SEQ_WATCHDOG_EN undefined: no counter; WAIT_DONE waits indefinitely.

## Structure
- Package `snn_pkg`:
  - state enum `seq_state_t`
  - localparams IMG_PIXELS = 784, ERR_BYTE = 8'hFF
- Sub-module `pixel_unpacker`:
  - 8-bit load/shift register plus 3-bit bit counter
  - outputs the current bit and a `last_bit` flag
  - instantiated once

## Test plan
- Reset, then 98 bytes of 8'hA5 -> 784 writes; address 0 data 1, address 1 data 0, address 783 data 1; exactly one core_start after the write to 783.
- Complete a frame, then drive core_done with core_digit=7 -> one cycle later tx_start with tx_data=8'h07; digit_out=7; busy falls 1 cycle after tx_done.
- Hold rx_rdy high during UNPACK/WAIT_DONE -> no clr_rx_rdy until IDLE; a byte pending at tx_done is consumed in the first IDLE cycle and written at address 0.
- Assert rst_n low after 50 bytes, release, then send 98 bytes -> writes restart at address 0; one core_start; digit_out=0 until core_done.
- With SNN_SEQ_WATCHDOG_EN and TIMEOUT_CYC=16, never assert core_done -> tx_data=8'hFF with tx_start 16 cycles after core_start; digit_out unchanged. A core_done in the timeout cycle transmits the digit instead.
